pc_redirect_unit: RTL and testbench

- Registered program counter and control-flow redirect unit for the pipelined MIPS datapath.
- Computes the branch-taken decision internally as Branch AND Zero from the EX stage. Combines it with Jump from ID, then selects the next PC.
- Generates a multi-cycle Flush to squash wrong-path instructions in the IF/ID and ID/EX registers.
- Keeps saturating statistics counters for taken branches and total redirects.

---
 rtl/pc_redirect_unit.sv | 115 +++++++++++
 tb/tb_pc_redirect_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
// Registered program counter with branch/jump redirect selection for the
// pipelined MIPS datapath. After each accepted redirect it raises a
// multi-cycle Flush that squashes the wrong-path instructions in IF/ID and
// ID/EX. It also keeps saturating counters of taken branches and of all
// redirects.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,   // legal range 1..3
  parameter int          CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Branch,
  input  logic             Zero,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             Stall,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             Flush,
  output logic             Misaligned,
  output logic [CNT_W-1:0] TakenCount,
  output logic [CNT_W-1:0] RedirectCount
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // fcnt holds the number of Flush cycles still to come after the current one.
  localparam logic [1:0]       FCNT_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [1:0]       fcnt, fcnt_nxt;
  logic [31:0]      pc_nxt;
  logic [31:0]      target;
  logic             flush_nxt;
  logic             mis_nxt;
  logic [CNT_W-1:0] taken_cnt_nxt;
  logic [CNT_W-1:0] redir_cnt_nxt;
  logic             taken;
  logic             redirect;

  assign taken    = Branch && Zero;
  assign redirect = taken || Jump;
  assign PCPlus4  = PC + 32'd4;

  // Next-state, next-PC and counter selection.
  // NOTE: every signal driven here is given a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    fcnt_nxt      = fcnt;
    pc_nxt        = Stall ? PC : PCPlus4;
    mis_nxt       = 1'b0;
    taken_cnt_nxt = TakenCount;
    redir_cnt_nxt = RedirectCount;
    // The older branch in EX takes priority over the younger jump in ID.
    target        = taken ? BranchTarget : JumpTarget;

    case (state)
      RUN: begin
        if (redirect) begin
          pc_nxt    = {target[31:2], 2'b00};
          mis_nxt   = |target[1:0];
          state_nxt = FLUSH;
          fcnt_nxt  = FCNT_INIT;
          if (RedirectCount != CNT_MAX) redir_cnt_nxt = RedirectCount + CNT_ONE;
          if (taken && (TakenCount != CNT_MAX)) taken_cnt_nxt = TakenCount + CNT_ONE;
        end
      end
      FLUSH: begin
        // The redirect inputs belong to squashed instructions and are ignored.
        // The countdown runs even while Stall holds the PC.
        if (fcnt == 2'd0) begin
          state_nxt = RUN;
        end else begin
          fcnt_nxt = fcnt - 2'd1;
        end
      end
      default: state_nxt = RUN;
    endcase

    flush_nxt = (state_nxt == FLUSH);
  end

  // State, PC, flag and counter registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values from before this edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= RUN;
      fcnt          <= 2'd0;
      PC            <= RESET_PC;
      Flush         <= 1'b0;
      Misaligned    <= 1'b0;
      TakenCount    <= '0;
      RedirectCount <= '0;
    end else begin
      state         <= state_nxt;
      fcnt          <= fcnt_nxt;
      PC            <= pc_nxt;
      Flush         <= flush_nxt;
      Misaligned    <= mis_nxt;
      TakenCount    <= taken_cnt_nxt;
      RedirectCount <= redir_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Testbench for pc_redirect_unit. It runs a directed walk through the main
// scenarios and then randomized traffic. Two instances share the stimulus:
// one uses the default 16-bit counters and the other uses 2-bit counters,
// so the second one shows counter saturation. A reference model tracks the
// PC, the number of flush cycles remaining and the raw event counts.
module tb_pc_redirect_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Branch, Zero, Jump, Stall;
  logic [31:0] BranchTarget, JumpTarget;

  logic [31:0] PC, PCPlus4;
  logic        Flush, Misaligned;
  logic [15:0] TakenCount, RedirectCount;

  logic [31:0] pc2, pc2_plus4;
  logic        flush2, mis2;
  logic [1:0]  taken2, redir2;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] exp_pc;
  int          flush_left;
  logic        exp_mis;
  int          taken_raw;
  int          redir_raw;

  always #5 Clk = ~Clk;

  pc_redirect_unit dut (
    .Clk(Clk), .Reset(Reset), .Branch(Branch), .Zero(Zero),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .Stall(Stall), .PC(PC), .PCPlus4(PCPlus4), .Flush(Flush),
    .Misaligned(Misaligned), .TakenCount(TakenCount),
    .RedirectCount(RedirectCount)
  );

  pc_redirect_unit #(.CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Branch(Branch), .Zero(Zero),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .Stall(Stall), .PC(pc2), .PCPlus4(pc2_plus4), .Flush(flush2),
    .Misaligned(mis2), .TakenCount(taken2), .RedirectCount(redir2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int raw, input int max);
    return (raw > max) ? max : raw;
  endfunction

  // The model advances by one clock edge using the current inputs.
  task automatic model_edge();
    if (Reset) begin
      exp_pc     = 32'h0;
      flush_left = 0;
      exp_mis    = 1'b0;
      taken_raw  = 0;
      redir_raw  = 0;
    end else if (flush_left > 0) begin
      if (!Stall) exp_pc = exp_pc + 32'd4;
      flush_left--;
      exp_mis = 1'b0;
    end else if (Branch && Zero) begin
      exp_pc     = BranchTarget & 32'hFFFF_FFFC;
      exp_mis    = (BranchTarget[1:0] != 2'b00);
      flush_left = 2;
      taken_raw++;
      redir_raw++;
    end else if (Jump) begin
      exp_pc     = JumpTarget & 32'hFFFF_FFFC;
      exp_mis    = (JumpTarget[1:0] != 2'b00);
      flush_left = 2;
      redir_raw++;
    end else begin
      if (!Stall) exp_pc = exp_pc + 32'd4;
      exp_mis = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("pc",        PC,            exp_pc);
    check("pcplus4",   PCPlus4,       exp_pc + 32'd4);
    check("flush",     32'(Flush),    32'(flush_left > 0));
    check("misalign",  32'(Misaligned), 32'(exp_mis));
    check("taken",     32'(TakenCount),    32'(sat(taken_raw, 65535)));
    check("redirect",  32'(RedirectCount), 32'(sat(redir_raw, 65535)));
    check("pc_sat",    pc2,           exp_pc);
    check("flush_sat", 32'(flush2),   32'(flush_left > 0));
    check("taken_sat", 32'(taken2),   32'(sat(taken_raw, 3)));
    check("redir_sat", 32'(redir2),   32'(sat(redir_raw, 3)));
  endtask

  // Apply one cycle of inputs, clock it, update the model and compare 1 ns later.
  task automatic step(input logic rst, input logic br, input logic zr,
                      input logic [31:0] bt, input logic jp,
                      input logic [31:0] jt, input logic st);
    Reset = rst; Branch = br; Zero = zr; BranchTarget = bt;
    Jump = jp; JumpTarget = jt; Stall = st;
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    exp_pc = 32'h0; flush_left = 0; exp_mis = 1'b0; taken_raw = 0; redir_raw = 0;
    Reset = 1'b1; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; Stall = 1'b0;
    BranchTarget = 32'h0; JumpTarget = 32'h0;
    #1;

    // Reset, then the free-running sequence.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("rst_pc", PC, 32'h0);
    check("rst_redir", 32'(RedirectCount), 32'h0);
    idle(4);
    check("seq_pc16", PC, 32'h10);

    // Taken branch to 0x100, followed by two flush cycles.
    step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    check("br_pc", PC, 32'h100);
    check("br_flush", 32'(Flush), 32'h1);
    idle(2);
    check("br_pc108", PC, 32'h108);
    idle(1);
    check("br_flush_end", 32'(Flush), 32'h0);

    // A not-taken branch with a jump, then branch and jump together.
    step(1'b0, 1'b1, 1'b0, 32'h500, 1'b1, 32'h40, 1'b0);
    check("jmp_pc", PC, 32'h40);
    check("jmp_taken", 32'(TakenCount), 32'h1);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0);
    check("brwins_pc", PC, 32'h80);
    idle(2);

    // Redirect overrides Stall; Stall during flush holds the PC.
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    check("stall_br_pc", PC, 32'h200);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("stall_hold_pc", PC, 32'h200);
    check("stall_flush_end", 32'(Flush), 32'h0);
    idle(1);

    // Misaligned target; a branch during flush is ignored.
    step(1'b0, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0, 1'b0);
    check("mis_pc", PC, 32'h200);
    check("mis_pulse", 32'(Misaligned), 32'h1);
    step(1'b0, 1'b1, 1'b1, 32'h700, 1'b1, 32'h800, 1'b0);
    check("mis_drop", 32'(Misaligned), 32'h0);
    check("ign_pc", PC, 32'h204);
    idle(2);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF4, 1'b0);
    idle(2);
    check("wrap_top", PC, 32'hFFFF_FFFC);
    idle(1);
    check("wrap_zero", PC, 32'h0);

    // Reset on the first flush cycle.
    step(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("rstfl_pc", PC, 32'h0);
    check("rstfl_flush", 32'(Flush), 32'h0);
    check("rstfl_cnt", 32'(TakenCount), 32'h0);

    // Five redirects saturate the 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i * 16), 1'b0);
      idle(2);
    end
    check("sat_redir2", 32'(redir2), 32'h3);
    check("sat_redir16", 32'(RedirectCount), 32'h5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_br, r_zr, r_jp, r_st;
      logic [31:0] r_bt, r_jt;
      r_rst = ($urandom_range(0, 199) == 0);
      r_br  = ($urandom_range(0, 99) < 30);
      r_zr  = $urandom_range(0, 1) == 1;
      r_jp  = ($urandom_range(0, 99) < 20);
      r_st  = ($urandom_range(0, 99) < 25);
      r_bt  = $urandom;
      r_jt  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r_rst, r_br, r_zr, r_bt, r_jp, r_jt, r_st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
